// File: rtl/block_fetch.sv
// Sequential tile fetcher: walks a BLK_ROWS x BLK_COLS window of a row-major matrix through a
// single-port synchronous RAM, zero-pads out-of-bounds elements and offers the tile on valid/ready.
module block_fetch #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int DIM_W    = 10,
  parameter int BLK_ROWS = 2,
  parameter int BLK_COLS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DIM_W-1:0]                 start_row,
  input  logic [DIM_W-1:0]                 start_col,
  input  logic [DIM_W-1:0]                 num_rows,
  input  logic [DIM_W-1:0]                 num_cols,
  input  logic [ADDR_W-1:0]                base_addr,
  output logic                             busy,
  output logic                             mem_rd_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W-1:0]                mem_rd_data,
  output logic                             block_valid,
  input  logic                             block_ready,
  output logic [BLK_ROWS*BLK_COLS*DATA_W-1:0] block_data
);

  localparam int N  = BLK_ROWS * BLK_COLS;
  localparam int RW = $clog2(BLK_ROWS + 1);
  localparam int CW = $clog2(BLK_COLS + 1);
  localparam int NW = $clog2(N + 1);
  localparam int LW = 2 * DIM_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t state, state_next;

  logic [DIM_W-1:0]  r_row, r_col, r_nrows, r_ncols;
  logic [ADDR_W-1:0] r_base;
  logic [RW-1:0]     i;
  logic [CW-1:0]     j;
  logic [NW-1:0]     idx;
  logic              pend, pend_inb;
  logic [NW-1:0]     pend_idx;

  logic [DIM_W:0]    row_abs, col_abs;
  logic [LW-1:0]     lin;
  logic              in_bounds, last, accept;

  // Absolute coordinates carry one extra bit so the bounds compare never wraps.
  assign row_abs   = {1'b0, r_row} + (DIM_W+1)'(i);
  assign col_abs   = {1'b0, r_col} + (DIM_W+1)'(j);
  assign in_bounds = (row_abs < {1'b0, r_nrows}) && (col_abs < {1'b0, r_ncols});
  assign lin       = LW'(row_abs) * LW'(r_ncols) + LW'(col_abs) + LW'(r_base);
  assign last      = (idx == NW'(N - 1));
  assign accept    = start && ((state == IDLE) || (state == HOLD && block_ready));

  assign busy        = (state != IDLE);
  assign block_valid = (state == HOLD);
  assign mem_rd_en   = (state == FETCH) && in_bounds;
  assign mem_addr    = mem_rd_en ? ADDR_W'(lin) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (last) state_next = DRAIN;
      DRAIN:   state_next = HOLD;
      HOLD:    if (block_ready) state_next = start ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each FETCH cycle leaves a pending slot write that lands one cycle later, when the RAM
  // data is valid; padding slots are written with zero on the same schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_nrows    <= '0;
      r_ncols    <= '0;
      r_base     <= '0;
      i          <= '0;
      j          <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      pend_inb   <= 1'b0;
      pend_idx   <= '0;
      block_data <= '0;
    end else begin
      if (accept) begin
        r_row   <= start_row;
        r_col   <= start_col;
        r_nrows <= num_rows;
        r_ncols <= num_cols;
        r_base  <= base_addr;
        i       <= '0;
        j       <= '0;
        idx     <= '0;
      end else if (state == FETCH) begin
        idx <= idx + NW'(1);
        if (j == CW'(BLK_COLS - 1)) begin
          j <= '0;
          i <= i + RW'(1);
        end else begin
          j <= j + CW'(1);
        end
      end
      pend     <= (state == FETCH);
      pend_inb <= in_bounds;
      pend_idx <= idx;
      if (pend)
        block_data[pend_idx*DATA_W +: DATA_W] <= pend_inb ? mem_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_block_fetch.sv
// Bench for block_fetch: directed vector table, hand-written handshake/reset sequences,
// then randomized tiles checked against a coordinate-level reference model.
module tb_block_fetch;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DIM_W  = 10;
  localparam int J      = 2;
  localparam int K      = 2;
  localparam int N      = J * K;

  logic                    clk = 1'b0;
  logic                    rst, start, block_ready;
  logic [DIM_W-1:0]        start_row, start_col, num_rows, num_cols;
  logic [ADDR_W-1:0]       base_addr, mem_addr;
  logic                    busy, mem_rd_en, block_valid;
  logic [DATA_W-1:0]       mem_rd_data;
  logic [N*DATA_W-1:0]     block_data;

  logic [DATA_W-1:0] mem [1024];
  int checks   = 0;
  int failures = 0;
  int rd_log[$];
  int exp_reads[$];

  typedef struct {
    int          sr, sc, nr, nc, base;
    logic [63:0] blk;
    int          nreads;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  block_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .BLK_ROWS(J), .BLK_COLS(K)) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_row(start_row), .start_col(start_col), .num_rows(num_rows), .num_cols(num_cols),
    .base_addr(base_addr), .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .block_valid(block_valid), .block_ready(block_ready),
    .block_data(block_data)
  );

  // Synchronous RAM with one cycle of read latency; unaffected by the DUT reset.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  always @(negedge clk) if (mem_rd_en) rd_log.push_back(int'(mem_addr));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sr, input int sc, input int nr, input int nc, input int base);
    start_row = DIM_W'(sr);
    start_col = DIM_W'(sc);
    num_rows  = DIM_W'(nr);
    num_cols  = DIM_W'(nc);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    start_row = DIM_W'($urandom);
    start_col = DIM_W'($urandom);
    num_rows  = DIM_W'($urandom);
    num_cols  = DIM_W'($urandom);
    base_addr = ADDR_W'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!block_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Reference: element (r,c) is mem[(base + row*pitch + col) mod 2^ADDR_W] when inside the matrix.
  task automatic model(input int sr, input int sc, input int nr, input int nc, input int base,
                       output logic [63:0] blk);
    int a;
    blk = '0;
    exp_reads.delete();
    for (int r = 0; r < J; r++)
      for (int c = 0; c < K; c++)
        if (sr + r < nr && sc + c < nc) begin
          a = (base + (sr + r) * nc + sc + c) % 1024;
          exp_reads.push_back(a);
          blk[(r*K + c)*DATA_W +: DATA_W] = mem[a];
        end
  endtask

  task automatic run_tile(input string name, input int sr, input int sc, input int nr, input int nc,
                          input int base, input logic [63:0] exp_blk, input int exp_n);
    int lat;
    logic [63:0] mblk;
    model(sr, sc, nr, nc, base, mblk);
    rd_log.delete();
    applyStimulus(sr, sc, nr, nc, base);
    wait_valid(lat);
    checkOutput({name, "_latency"}, 64'(lat), 64'(N + 1));
    checkOutput({name, "_block"}, block_data, exp_blk);
    checkOutput({name, "_nreads"}, 64'(rd_log.size()), 64'(exp_n));
    for (int k = 0; k < exp_reads.size() && k < rd_log.size(); k++)
      checkOutput({name, "_addr"}, 64'(rd_log[k]), 64'(exp_reads[k]));
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, 64'(block_valid), 64'd0);
    checkOutput({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, n0;
    logic [63:0] held, mblk;
    int sr, sc, nr, nc, base;

    vecs[0] = '{1, 1, 4, 4, 0,    {16'd10, 16'd9, 16'd6, 16'd5}, 4};
    vecs[1] = '{3, 3, 4, 4, 0,    {16'd0, 16'd0, 16'd0, 16'd15}, 1};
    vecs[2] = '{4, 0, 4, 4, 0,    64'd0, 0};
    vecs[3] = '{0, 0, 0, 4, 0,    64'd0, 0};
    vecs[4] = '{1, 2, 4, 32, 1000, {16'd43, 16'd42, 16'd11, 16'd10}, 4};
    vecs[5] = '{0, 3, 4, 4, 0,    {16'd0, 16'd7, 16'd0, 16'd3}, 2};
    vecs[6] = '{3, 0, 4, 4, 0,    {16'd0, 16'd0, 16'd13, 16'd12}, 2};
    vecs[7] = '{2, 2, 4, 4, 16,   {16'd31, 16'd30, 16'd27, 16'd26}, 4};

    for (int a = 0; a < 1024; a++) mem[a] = DATA_W'(a);
    rst = 1'b1; start = 1'b0; block_ready = 1'b0;
    start_row = '0; start_col = '0; num_rows = '0; num_cols = '0; base_addr = '0;
    tick(); tick();
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("reset_valid", 64'(block_valid), 64'd0);
    checkOutput("reset_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_data", block_data, 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++)
      run_tile($sformatf("vec%0d", v), vecs[v].sr, vecs[v].sc, vecs[v].nr, vecs[v].nc,
               vecs[v].base, vecs[v].blk, vecs[v].nreads);

    // Backpressure: tile must hold still and a start pulse must be ignored.
    rd_log.delete();
    applyStimulus(1, 1, 4, 4, 0);
    wait_valid(lat);
    held = {16'd10, 16'd9, 16'd6, 16'd5};
    n0 = rd_log.size();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      start_row = '0; start_col = '0; num_rows = 10'd4; num_cols = 10'd4;
      tick();
      start = 1'b0;
      checkOutput("bp_data", block_data, held);
      checkOutput("bp_valid", 64'(block_valid), 64'd1);
    end
    checkOutput("bp_no_reads", 64'(rd_log.size()), 64'(n0));
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    checkOutput("bp_valid_drop", 64'(block_valid), 64'd0);
    checkOutput("bp_idle", 64'(busy), 64'd0);

    // Back-to-back: handshake with start restarts fetching with no idle cycle.
    applyStimulus(1, 1, 4, 4, 0);
    wait_valid(lat);
    start_row = '0; start_col = '0; num_rows = 10'd4; num_cols = 10'd4; base_addr = '0;
    start = 1'b1; block_ready = 1'b1;
    tick();
    start = 1'b0; block_ready = 1'b0;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    checkOutput("b2b_valid", 64'(block_valid), 64'd0);
    checkOutput("b2b_rd_en", 64'(mem_rd_en), 64'd1);
    checkOutput("b2b_addr", 64'(mem_addr), 64'd0);
    wait_valid(lat);
    checkOutput("b2b_latency", 64'(lat), 64'(N + 1));
    checkOutput("b2b_block", block_data, {16'd5, 16'd4, 16'd1, 16'd0});
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;

    // Reset in the second FETCH cycle aborts and discards the in-flight read.
    applyStimulus(1, 1, 4, 4, 0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("rst_valid", 64'(block_valid), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_data", block_data, 64'd0);
    rst = 1'b0;
    run_tile("after_rst", 0, 0, 4, 4, 0, {16'd5, 16'd4, 16'd1, 16'd0}, 4);

    for (int a = 0; a < 1024; a++) mem[a] = DATA_W'($urandom);
    for (int t = 0; t < 40; t++) begin
      sr   = int'($urandom_range(0, 9));
      sc   = int'($urandom_range(0, 41));
      nr   = int'($urandom_range(0, 8));
      nc   = int'($urandom_range(0, 40));
      base = int'($urandom_range(0, 1023));
      model(sr, sc, nr, nc, base, mblk);
      run_tile($sformatf("rand%0d", t), sr, sc, nr, nc, base, mblk, exp_reads.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
